ternary_weight_loader: RTL and testbench

- Write-side front end for the wide SRAM weight buffer.
- Accepts a stream of 2-bit ternary weights (+1 = 01, 0 = 00, -1 = 11) over a valid/ready handshake.
- Packs four consecutive weights into one 8-bit word and issues one active-low SRAM write per word. Word address steps by 4 from a programmed base.
- Sits between the weight DMA/host interface and the buffer's write port (enable, wr_en, in_data, addr).

---
 rtl/ternary_weight_loader.sv | 147 ++++++++++++++
 tb/tb_ternary_weight_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_weight_loader.sv
// Ternary weight loader: packs four 2-bit weights per word and writes them to the SRAM weight buffer.
// Optional macro WLOAD_TERNARY_CHECK_EN zeroes illegal 2'b10 weights and raises a sticky err.
module ternary_weight_loader #(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_weights,
    input  logic              w_valid,
    input  logic [1:0]        w_data,
    output logic              w_ready,
    output logic              busy,
    output logic              done,
    output logic              sram_enable,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_in_data
`ifdef WLOAD_TERNARY_CHECK_EN
    ,
    output logic              err
`endif
);

    // Counter must hold both any num_weights value and the full buffer size.
    localparam int RW = (CNT_W > ADDR_W) ? CNT_W : ADDR_W + 1;
    localparam logic [RW-1:0] MAXW = RW'(1) << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FIN
    } state_t;

    state_t        state;
    logic [RW-1:0] remaining;
    logic [1:0]    slot;
    logic [RW-1:0] num_ext;
    logic [RW-1:0] num_clamp;
    logic [1:0]    wd;
    logic          accept;
    logic          last;
`ifdef WLOAD_TERNARY_CHECK_EN
    logic          illegal;
`endif

    // Clamp the requested count to the buffer capacity.
    always_comb begin
        num_ext   = RW'(num_weights);
        num_clamp = (num_ext > MAXW) ? MAXW : num_ext;
    end

    // Weight actually packed, with illegal codes optionally squashed to zero.
    always_comb begin
        wd = w_data;
`ifdef WLOAD_TERNARY_CHECK_EN
        illegal = 1'b0;
        if (w_data == 2'b10) begin
            wd      = 2'b00;
            illegal = 1'b1;
        end
`endif
    end

    assign accept = w_valid & w_ready;
    assign last   = (slot == 2'd3) || (remaining == RW'(1));

    // Load sequencer with registered handshake and SRAM outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            slot         <= '0;
            w_ready      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sram_enable  <= 1'b1;
            sram_wr_en   <= 1'b1;
            sram_addr    <= '0;
            sram_in_data <= '0;
`ifdef WLOAD_TERNARY_CHECK_EN
            err          <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sram_addr    <= base_addr & ~ADDR_W'(3);
                        remaining    <= num_clamp;
                        slot         <= '0;
                        sram_in_data <= '0;
                        busy         <= 1'b1;
                        sram_enable  <= 1'b0;
`ifdef WLOAD_TERNARY_CHECK_EN
                        err          <= 1'b0;
`endif
                        if (num_clamp == '0) begin
                            state <= FIN;
                        end else begin
                            state   <= COLLECT;
                            w_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        sram_in_data[{slot, 1'b0} +: 2] <= wd;
                        remaining <= remaining - RW'(1);
                        slot      <= slot + 2'd1;
`ifdef WLOAD_TERNARY_CHECK_EN
                        if (illegal) err <= 1'b1;
`endif
                        if (last) begin
                            state      <= WRITE;
                            w_ready    <= 1'b0;
                            sram_wr_en <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    sram_wr_en   <= 1'b1;
                    sram_addr    <= sram_addr + ADDR_W'(4);
                    slot         <= '0;
                    sram_in_data <= '0;
                    if (remaining != '0) begin
                        state   <= COLLECT;
                        w_ready <= 1'b1;
                    end else begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    sram_enable <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Self-checking bench for ternary_weight_loader: directed cases plus randomized loads
// compared against a word-level packing model.
module tb_ternary_weight_loader;

    localparam int AW = 7;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_weights;
    logic          w_valid;
    logic [1:0]    w_data;
    logic          w_ready;
    logic          busy;
    logic          done;
    logic          sram_enable;
    logic          sram_wr_en;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_in_data;
`ifdef WLOAD_TERNARY_CHECK_EN
    logic          err;
`endif

    ternary_weight_loader #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .num_weights(num_weights),
        .w_valid(w_valid),
        .w_data(w_data),
        .w_ready(w_ready),
        .busy(busy),
        .done(done),
        .sram_enable(sram_enable),
        .sram_wr_en(sram_wr_en),
        .sram_addr(sram_addr),
        .sram_in_data(sram_in_data)
`ifdef WLOAD_TERNARY_CHECK_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [14:0] wr_q[$];
    int          wr_cyc[$];
    int          done_cnt = 0;
    int          wr_run = 0;
    int          wr_long = 0;

    always @(posedge clk) cyc++;

    // Observe SRAM writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (sram_wr_en === 1'b0) begin
            wr_q.push_back({sram_addr, sram_in_data});
            wr_cyc.push_back(cyc);
            wr_run++;
            if (wr_run > 1) wr_long++;
        end else begin
            wr_run = 0;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc.delete();
        done_cnt = 0;
        wr_long  = 0;
    endtask

    // Reference: words of four weights, zero padded, at base&~3 stepping by 4 mod 128.
    task automatic expect_writes(input string tag, input logic [AW-1:0] base,
                                 input logic [1:0] ws[$]);
        int nw;
        int nwords;
        int a;
        int d;
        int v;
        nw     = ws.size();
        nwords = (nw + 3) / 4;
        chk({tag, " nwrites"}, wr_q.size(), nwords);
        for (int k = 0; k < nwords; k++) begin
            d = 0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < nw) begin
                    v = int'(ws[4 * k + j]);
`ifdef WLOAD_TERNARY_CHECK_EN
                    if (v == 2) v = 0;
`endif
                    d = d + v * (1 << (2 * j));
                end
            end
            a = ((int'(base) / 4) * 4 + 4 * k) % 128;
            if (k < wr_q.size()) begin
                chk({tag, " addr"}, 32'(wr_q[k][14:8]), a);
                chk({tag, " data"}, 32'(wr_q[k][7:0]), d);
            end
        end
        chk({tag, " done_cnt"}, done_cnt, 1);
        chk({tag, " wr_len"}, wr_long, 0);
    endtask

    // mode 0: continuous valid, 1: one on two off, 2: random ~70% valid.
    task automatic run_load(input logic [AW-1:0] base, input logic [CW-1:0] n,
                            input logic [1:0] ws[$], input int mode, input bit mid_start,
                            output int t0);
        int i;
        int budget;
        bit v;
        @(negedge clk);
        clear_mon();
        t0          = cyc;
        base_addr   = base;
        num_weights = n;
        start       = 1'b1;
        i           = 0;
        budget      = 0;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && budget < 2000) begin
            if (mid_start && budget == 3) begin
                start       = 1'b1;
                base_addr   = 7'd64;
                num_weights = 8'd20;
            end else begin
                start = 1'b0;
            end
            if (i < ws.size()) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (budget % 3 == 0);
                    default: v = ($urandom_range(99) < 70);
                endcase
                w_valid = v;
                w_data  = v ? ws[i] : 2'($urandom);
                if (v && w_ready === 1'b1) i++;
            end else begin
                w_valid = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        start   = 1'b0;
        w_valid = 1'b0;
        chk("done timeout", 32'(budget < 2000), 1);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] ws[$];
        logic [AW-1:0] b;
        logic [CW-1:0] n;
        int t0;
        int nc;
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_weights = '0;
        w_valid     = 1'b0;
        w_data      = '0;
        repeat (3) @(negedge clk);
        chk("rst w_ready", 32'(w_ready), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst enable", 32'(sram_enable), 1);
        chk("rst wr_en", 32'(sram_wr_en), 1);
        chk("rst addr", 32'(sram_addr), 0);
        chk("rst data", 32'(sram_in_data), 0);
`ifdef WLOAD_TERNARY_CHECK_EN
        chk("rst err", 32'(err), 0);
`endif
        reset = 1'b0;

        // Two full words back to back.
        ws = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00};
        run_load(7'd0, 8'd8, ws, 0, 1'b0, t0);
        expect_writes("t1", 7'd0, ws);
        if (wr_q.size() == 2) begin
            chk("t1 w0", 32'(wr_q[0]), {7'd0, 8'b01_00_11_01});
            chk("t1 w1", 32'(wr_q[1]), {7'd4, 8'b00_01_11_11});
            chk("t1 lat0", wr_cyc[0] - t0, 5);
            chk("t1 lat1", wr_cyc[1] - t0, 10);
        end
        chk("t1 idle busy", 32'(busy), 0);

        // Unaligned base near the top wraps to zero with padding.
        ws = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        run_load(7'd126, 8'd6, ws, 0, 1'b0, t0);
        expect_writes("wrap", 7'd126, ws);
        if (wr_q.size() == 2) begin
            chk("wrap w0", 32'(wr_q[0]), {7'd124, 8'h55});
            chk("wrap w1", 32'(wr_q[1]), {7'd0, 8'h05});
        end

        // Zero-length load: one busy cycle, done two cycles after start.
        @(negedge clk);
        clear_mon();
        base_addr   = 7'd40;
        num_weights = 8'd0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("z busy1", 32'(busy), 1);
        chk("z done1", 32'(done), 0);
        chk("z en1", 32'(sram_enable), 0);
        @(negedge clk);
        chk("z busy2", 32'(busy), 0);
        chk("z done2", 32'(done), 1);
        chk("z en2", 32'(sram_enable), 1);
        @(negedge clk);
        chk("z done3", 32'(done), 0);
        chk("z nwrites", wr_q.size(), 0);

        // Gapped stream with an ignored second start.
        ws = '{2'b11, 2'b00, 2'b01, 2'b11};
        run_load(7'd20, 8'd4, ws, 1, 1'b1, t0);
        expect_writes("gap", 7'd20, ws);
        repeat (4) @(negedge clk);
        chk("gap quiet", 32'(busy), 0);
        chk("gap nwrites after", wr_q.size(), 1);

        // Reset after two accepted weights aborts the load.
        @(negedge clk);
        clear_mon();
        base_addr   = 7'd8;
        num_weights = 8'd4;
        start       = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        w_valid = 1'b1;
        w_data  = 2'b01;
        @(negedge clk);
        w_data = 2'b11;
        @(negedge clk);
        w_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ab w_ready", 32'(w_ready), 0);
        chk("ab busy", 32'(busy), 0);
        chk("ab done", 32'(done), 0);
        chk("ab enable", 32'(sram_enable), 1);
        chk("ab wr_en", 32'(sram_wr_en), 1);
        chk("ab addr", 32'(sram_addr), 0);
        chk("ab data", 32'(sram_in_data), 0);
        repeat (6) @(negedge clk);
        chk("ab nwrites", wr_q.size(), 0);
        chk("ab done_cnt", done_cnt, 0);

`ifdef WLOAD_TERNARY_CHECK_EN
        ws = '{2'b10, 2'b01, 2'b01, 2'b01};
        run_load(7'd0, 8'd4, ws, 0, 1'b0, t0);
        expect_writes("ill", 7'd0, ws);
        if (wr_q.size() == 1) chk("ill w0", 32'(wr_q[0][7:0]), 8'b01_01_01_00);
        repeat (3) @(negedge clk);
        chk("ill err held", 32'(err), 1);
        @(negedge clk);
        num_weights = 8'd0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ill err clr", 32'(err), 0);
        repeat (3) @(negedge clk);
`endif

        // Randomized loads, including one clamped to the buffer size.
        for (int r = 0; r < 8; r++) begin
            b = AW'($urandom);
            n = (r == 5) ? 8'd200 : CW'($urandom_range(1, 40));
            nc = (int'(n) > 128) ? 128 : int'(n);
            ws.delete();
            for (int k = 0; k < nc; k++) ws.push_back(2'($urandom));
            run_load(b, n, ws, (r % 2 == 0) ? 2 : 0, 1'b0, t0);
            expect_writes("rand", b, ws);
`ifdef WLOAD_TERNARY_CHECK_EN
            chk("rand err", 32'(err), 32'(ws.sum() with (int'(item == 2'b10)) != 0));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
